// File: rtl/i2c_bus_pkg.sv
// i2c_bus_pkg: shared bus-state type, parameter defaults and legal ranges
package i2c_bus_pkg;
   typedef enum logic {IDLE, BUSY} bus_state_t;
   localparam int NUM_DEV_DEF     = 2;
   localparam int NUM_DEV_MIN     = 1;
   localparam int NUM_DEV_MAX     = 8;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 3;
   localparam int FILTER_LEN_DEF  = 4;
   localparam int FILTER_LEN_MIN  = 1;
   localparam int FILTER_LEN_MAX  = 15;
   localparam int TIMEOUT_CYC_DEF = 1000;
   localparam int TIMEOUT_CYC_MIN = 1;
   localparam int FILT_CNT_W      = $clog2(FILTER_LEN_MAX + 1);
   function automatic bit cfg_ok(int n, int s, int f, int t);
      return n >= NUM_DEV_MIN && n <= NUM_DEV_MAX && s >= SYNC_STAGES_MIN && s <= SYNC_STAGES_MAX &&
             f >= FILTER_LEN_MIN && f <= FILTER_LEN_MAX && t >= TIMEOUT_CYC_MIN;
   endfunction
endpackage

// File: rtl/i2c_bus_resolver_if.sv
// i2c_bus_resolver_if: device drive/enable inputs and resolved bus status
interface i2c_bus_resolver_if import i2c_bus_pkg::*; #(parameter int NUM_DEV = NUM_DEV_DEF);
   logic [NUM_DEV-1:0] DEV_SCL_O, DEV_SDA_O, DEV_SCL_OEN, DEV_SDA_OEN, ARB_CLR, ARB_LOST;
   logic SCL_PAD_I, SDA_PAD_I, SCL_FILT, SDA_FILT, START_DET, STOP_DET, BUS_BUSY, SCL_TIMEOUT;
   modport master (
      output DEV_SCL_O, DEV_SDA_O, DEV_SCL_OEN, DEV_SDA_OEN, ARB_CLR,
      input  SCL_PAD_I, SDA_PAD_I, SCL_FILT, SDA_FILT, START_DET, STOP_DET, BUS_BUSY, ARB_LOST, SCL_TIMEOUT
   );
   modport slave (
      input  DEV_SCL_O, DEV_SDA_O, DEV_SCL_OEN, DEV_SDA_OEN, ARB_CLR,
      output SCL_PAD_I, SDA_PAD_I, SCL_FILT, SDA_FILT, START_DET, STOP_DET, BUS_BUSY, ARB_LOST, SCL_TIMEOUT
   );
endinterface

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: reset-to-1 synchronizer followed by a stable-for-FILTER_LEN glitch filter
module i2c_line_filter import i2c_bus_pkg::*; #(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filt
);
   logic [SYNC_STAGES-1:0] sync;
   logic [FILT_CNT_W-1:0] cnt;
   logic diff, hit;
   assign diff = sync[SYNC_STAGES-1] ^ filt;
   assign hit  = diff && cnt == FILT_CNT_W'(FILTER_LEN - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync <= '1;
         cnt  <= '0;
         filt <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
         cnt  <= (diff && !hit) ? cnt + 1'b1 : '0;
         filt <= hit ? sync[SYNC_STAGES-1] : filt;
      end
endmodule

// File: rtl/i2c_bus_resolver.sv
// i2c_bus_resolver: wired-AND I2C bus model with filtering, START/STOP, arbitration; I2C_BUS_TIMEOUT_EN adds SCL-low timeout
module i2c_bus_resolver import i2c_bus_pkg::*; #(
   parameter int NUM_DEV     = NUM_DEV_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int FILTER_LEN  = FILTER_LEN_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input logic WB_CLK_I,
   input logic WB_RST_I,
   i2c_bus_resolver_if.slave bus
);
   if (!cfg_ok(NUM_DEV, SYNC_STAGES, FILTER_LEN, TIMEOUT_CYC)) begin : g_bad_cfg
      $error("i2c_bus_resolver: parameter out of range");
   end
   logic scl_f, sda_f, scl_q, sda_q, start_c, stop_c, scl_rise;
   logic [NUM_DEV-1:0] sda_low, arb_set;
   bus_state_t state, state_nxt;
   assign bus.SCL_PAD_I = &(bus.DEV_SCL_OEN | bus.DEV_SCL_O);
   assign bus.SDA_PAD_I = &(bus.DEV_SDA_OEN | bus.DEV_SDA_O);
   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
      .clk(WB_CLK_I), .rst(WB_RST_I), .raw(bus.SCL_PAD_I), .filt(scl_f));
   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
      .clk(WB_CLK_I), .rst(WB_RST_I), .raw(bus.SDA_PAD_I), .filt(sda_f));
   assign bus.SCL_FILT = scl_f;
   assign bus.SDA_FILT = sda_f;
   // SCL must be high on both sides of the SDA edge, so a simultaneous SCL change masks detection
   assign start_c  = scl_q & scl_f & sda_q & ~sda_f;
   assign stop_c   = scl_q & scl_f & ~sda_q & sda_f;
   assign scl_rise = ~scl_q & scl_f;
   assign sda_low  = ~bus.DEV_SDA_OEN & ~bus.DEV_SDA_O;
   for (genvar g = 0; g < NUM_DEV; g++) begin : g_arb
      assign arb_set[g] = bus.BUS_BUSY & scl_rise & ~sda_f & ~sda_low[g] & |(sda_low & ~(NUM_DEV'(1) << g));
   end
   always_comb state_nxt = start_c ? BUSY : stop_c ? IDLE : state;
   assign bus.BUS_BUSY = state == BUSY;
   always_ff @(posedge WB_CLK_I or posedge WB_RST_I)
      if (WB_RST_I) begin
         state         <= IDLE;
         scl_q         <= 1'b1;
         sda_q         <= 1'b1;
         bus.START_DET <= 1'b0;
         bus.STOP_DET  <= 1'b0;
         bus.ARB_LOST  <= '0;
      end else begin
         state         <= state_nxt;
         scl_q         <= scl_f;
         sda_q         <= sda_f;
         bus.START_DET <= start_c;
         bus.STOP_DET  <= stop_c;
         bus.ARB_LOST  <= arb_set | (bus.ARB_LOST & ~bus.ARB_CLR);
      end
`ifdef I2C_BUS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;
   logic to_hit;
   assign to_hit = to_cnt == TO_W'(TIMEOUT_CYC);
   always_ff @(posedge WB_CLK_I or posedge WB_RST_I)
      if (WB_RST_I) begin
         to_cnt          <= '0;
         bus.SCL_TIMEOUT <= 1'b0;
      end else begin
         to_cnt          <= (scl_f || !bus.BUS_BUSY) ? '0 : to_hit ? to_cnt : to_cnt + 1'b1;
         bus.SCL_TIMEOUT <= bus.STOP_DET ? 1'b0 : to_hit | bus.SCL_TIMEOUT;
      end
`else
   assign bus.SCL_TIMEOUT = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_bus_resolver.sv
// tb_i2c_bus_resolver: directed and random stimulus checked against a window-based bus model
module tb_i2c_bus_resolver;
   localparam int N = 2, S = 2, FL = 4;
`ifdef I2C_BUS_TIMEOUT_EN
   localparam int TO = 20;
   localparam logic TO_EXP = 1'b1;
`else
   localparam int TO = 1000;
   localparam logic TO_EXP = 1'b0;
`endif
   typedef logic lq_t[$];
   logic clk = 1'b0, rst = 1'b1;
   int errors = 0, checks = 0;
   i2c_bus_resolver_if #(.NUM_DEV(N)) bus ();
   i2c_bus_resolver #(.NUM_DEV(N), .SYNC_STAGES(S), .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
      .WB_CLK_I(clk), .WB_RST_I(rst), .bus(bus));
   always #5 clk = ~clk;

   logic m_scl, m_sda, p_scl, p_sda, m_busy, m_start, m_stop, m_to;
   logic [N-1:0] m_arb;
   lq_t q_scl, q_sda;
   int to_run;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic wired_and(input logic [N-1:0] o, input logic [N-1:0] oen);
      for (int i = 0; i < N; i++) if (!oen[i] && !o[i]) return 1'b0;
      return 1'b1;
   endfunction

   // the filtered line flips once the FL synchronized samples ending S edges ago all disagree with it
   function automatic bit window_flip(input lq_t q, input logic f);
      for (int k = S - 1; k <= S + FL - 2; k++) if (q[k] == f) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      {m_scl, m_sda, p_scl, p_sda} = 4'hf;
      {m_busy, m_start, m_stop, m_to} = 4'h0;
      m_arb = '0;
      to_run = 0;
      q_scl = {};
      q_sda = {};
      repeat (S + FL - 1) begin
         q_scl.push_back(1'b1);
         q_sda.push_back(1'b1);
      end
   endtask

   task automatic model_step();
      logic st, sp, others;
      logic [N-1:0] low;
      st = p_sda && !m_sda && p_scl && m_scl;
      sp = !p_sda && m_sda && p_scl && m_scl;
      for (int i = 0; i < N; i++) low[i] = !bus.DEV_SDA_OEN[i] && !bus.DEV_SDA_O[i];
      for (int i = 0; i < N; i++) begin
         others = 1'b0;
         for (int j = 0; j < N; j++) if (j != i && low[j]) others = 1'b1;
         m_arb[i] = (m_busy && !p_scl && m_scl && !m_sda && !low[i] && others) || (m_arb[i] && !bus.ARB_CLR[i]);
      end
`ifdef I2C_BUS_TIMEOUT_EN
      m_to = m_stop ? 1'b0 : (to_run >= TO) || m_to;
`endif
      to_run = (m_scl || !m_busy) ? 0 : to_run + 1;
      if (st) m_busy = 1'b1;
      else if (sp) m_busy = 1'b0;
      m_start = st;
      m_stop = sp;
      p_scl = m_scl;
      p_sda = m_sda;
      if (window_flip(q_scl, m_scl)) m_scl = !m_scl;
      if (window_flip(q_sda, m_sda)) m_sda = !m_sda;
      q_scl.push_front(wired_and(bus.DEV_SCL_O, bus.DEV_SCL_OEN));
      q_sda.push_front(wired_and(bus.DEV_SDA_O, bus.DEV_SDA_OEN));
      void'(q_scl.pop_back());
      void'(q_sda.pop_back());
   endtask

   always @(negedge clk) if (!rst) begin
      chk("scl_pad", bus.SCL_PAD_I, wired_and(bus.DEV_SCL_O, bus.DEV_SCL_OEN));
      chk("sda_pad", bus.SDA_PAD_I, wired_and(bus.DEV_SDA_O, bus.DEV_SDA_OEN));
      chk("scl_filt", bus.SCL_FILT, m_scl);
      chk("sda_filt", bus.SDA_FILT, m_sda);
      chk("start_det", bus.START_DET, m_start);
      chk("stop_det", bus.STOP_DET, m_stop);
      chk("bus_busy", bus.BUS_BUSY, m_busy);
      chk("arb_lost", bus.ARB_LOST, m_arb);
      chk("scl_timeout", bus.SCL_TIMEOUT, m_to);
   end

   task automatic tick();
      @(posedge clk);
      if (!rst) model_step();
      #1;
   endtask

   task automatic dev(input int d, input logic scl, input logic sda);
      bus.DEV_SCL_OEN[d] = scl;
      bus.DEV_SDA_OEN[d] = sda;
      bus.DEV_SCL_O[d] = 1'b0;
      bus.DEV_SDA_O[d] = 1'b0;
   endtask

   task automatic wait_line(input bit scl, input logic v, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while ((scl ? bus.SCL_FILT : bus.SDA_FILT) !== v && n < 20);
   endtask

   task automatic run(input int cyc, output int starts, output int stops);
      starts = 0;
      stops = 0;
      repeat (cyc) begin
         tick();
         if (bus.START_DET) starts++;
         if (bus.STOP_DET) stops++;
      end
   endtask

   initial begin
      int n, st, sp, lows;
      bus.DEV_SCL_O = '1;
      bus.DEV_SDA_O = '1;
      bus.DEV_SCL_OEN = '1;
      bus.DEV_SDA_OEN = '1;
      bus.ARB_CLR = '0;
      model_reset();
      #12;
      chk("rst_filt", {bus.SCL_FILT, bus.SDA_FILT}, 2'b11);
      chk("rst_flags", {bus.START_DET, bus.STOP_DET, bus.BUS_BUSY, bus.ARB_LOST, bus.SCL_TIMEOUT}, 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      // 3-cycle glitch on SDA is swallowed by the filter
      dev(0, 1'b1, 1'b0);
      lows = 0;
      repeat (3) begin
         #1 chk("glitch_pad", bus.SDA_PAD_I, 1'b0);
         tick();
      end
      dev(0, 1'b1, 1'b1);
      repeat (10) begin
         tick();
         if (!bus.SDA_FILT || bus.START_DET) lows++;
      end
      chk("glitch_filt", lows, 0);
      // START then STOP
      dev(0, 1'b1, 1'b0);
      wait_line(1'b0, 1'b0, n);
      chk("start_latency", n, 6);
      tick();
      chk("start_pulse", {bus.START_DET, bus.BUS_BUSY}, 2'b11);
      tick();
      chk("start_end", {bus.START_DET, bus.BUS_BUSY}, 2'b01);
      dev(0, 1'b1, 1'b1);
      wait_line(1'b0, 1'b1, n);
      chk("stop_latency", n, 6);
      tick();
      chk("stop_pulse", {bus.STOP_DET, bus.BUS_BUSY}, 2'b10);
      tick();
      chk("stop_end", bus.STOP_DET, 1'b0);
      // simultaneous SCL/SDA changes
      dev(0, 1'b0, 1'b0);
      run(12, st, sp);
      dev(0, 1'b1, 1'b1);
      run(12, n, lows);
      chk("simul_det", st + sp + n + lows, 0);
      chk("simul_busy", bus.BUS_BUSY, 1'b0);
      // arbitration loss for dev0
      dev(0, 1'b1, 1'b0);
      repeat (8) tick();
      chk("arb_busy", bus.BUS_BUSY, 1'b1);
      dev(0, 1'b0, 1'b0);
      repeat (8) tick();
      dev(0, 1'b1, 1'b1);
      dev(1, 1'b1, 1'b0);
      wait_line(1'b1, 1'b1, n);
      chk("scl_rise_latency", n, 6);
      bus.ARB_CLR = 2'b01;
      tick();
      bus.ARB_CLR = 2'b00;
      chk("arb_set_wins", bus.ARB_LOST, 2'b01);
      tick();
      chk("arb_sticky", bus.ARB_LOST, 2'b01);
      bus.ARB_CLR = 2'b01;
      tick();
      bus.ARB_CLR = 2'b00;
      chk("arb_clr", bus.ARB_LOST, 2'b00);
      // SCL held low while busy
      dev(0, 1'b0, 1'b1);
      repeat (30) tick();
      chk("timeout_set", bus.SCL_TIMEOUT, TO_EXP);
      dev(0, 1'b1, 1'b1);
      repeat (8) tick();
      chk("timeout_sticky", bus.SCL_TIMEOUT, TO_EXP);
      dev(1, 1'b1, 1'b1);
      repeat (10) tick();
      chk("timeout_clr", {bus.SCL_TIMEOUT, bus.BUS_BUSY}, 2'b00);
      // reset mid-transfer
      dev(0, 1'b1, 1'b0);
      repeat (8) tick();
      dev(0, 1'b0, 1'b0);
      repeat (8) tick();
      #2 rst = 1'b1;
      model_reset();
      dev(0, 1'b1, 1'b1);
      #1;
      chk("midrst_filt", {bus.SCL_FILT, bus.SDA_FILT}, 2'b11);
      chk("midrst_flags", {bus.START_DET, bus.STOP_DET, bus.BUS_BUSY, bus.ARB_LOST, bus.SCL_TIMEOUT}, 0);
      tick();
      rst = 1'b0;
      run(10, st, sp);
      chk("postrst_quiet", {st[7:0], sp[7:0], 7'd0, bus.BUS_BUSY}, 0);
      // random traffic
      repeat (300) begin
         for (int d = 0; d < N; d++) begin
            bus.DEV_SCL_OEN[d] = $urandom_range(0, 2) != 0;
            bus.DEV_SDA_OEN[d] = $urandom_range(0, 2) != 0;
            bus.DEV_SCL_O[d] = 1'($urandom_range(0, 1));
            bus.DEV_SDA_O[d] = 1'($urandom_range(0, 1));
         end
         bus.ARB_CLR = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         repeat ($urandom_range(1, 9)) tick();
      end
      bus.ARB_CLR = '0;
      for (int d = 0; d < N; d++) dev(d, 1'b1, 1'b1);
      repeat (12) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/i2c_bus_resolver.md
I2C_BUS_RESOLVER -- requirements
Module: i2c_bus_resolver

Interface
REQ-001 SHALL have parameter NUM_DEV, default 2, number of attached open-drain devices (range 1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on the resolved lines (range 2..3).
REQ-003 SHALL have parameter FILTER_LEN, default 4, consecutive stable cycles required before a filtered line changes (range 1..15).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000, SCL-low cycle limit (used only when the timeout feature is compiled in).
REQ-005 WB_CLK_I  input  1  single clock; all state updates on its rising edge.
REQ-006 WB_RST_I  input  1  asynchronous, active-high reset.
REQ-007 DEV_SCL_O / DEV_SDA_O  input  NUM_DEV  per-device drive value.
REQ-008 DEV_SCL_OEN / DEV_SDA_OEN  input  NUM_DEV  per-device output enable, active-low (1 = released).
REQ-009 SCL_PAD_I / SDA_PAD_I  output  1  resolved raw line, combinational, fed back to every device.
REQ-010 SCL_FILT / SDA_FILT  output  1  synchronized and glitch-filtered line.
REQ-011 START_DET / STOP_DET  output  1  one-cycle pulse per detected condition.
REQ-012 BUS_BUSY  output  1  level, high between START and STOP.
REQ-013 ARB_LOST  output  NUM_DEV  sticky per-device arbitration-loss flag.
REQ-014 ARB_CLR  input  NUM_DEV  per-device clear strobe for ARB_LOST.
REQ-015 SCL_TIMEOUT  output  1  sticky SCL-stuck-low flag.

Function
REQ-016 Raw line SHALL be the wired-AND over devices of (OEN ? 1 : O); all released, or NUM_DEV devices idle, gives 1 (pull-up).
REQ-017 Each raw line SHALL pass through SYNC_STAGES flops, then the filter.
REQ-018 Filter: the counter SHALL reset to 0 whenever the synchronized value equals the filtered value; when it differs for FILTER_LEN consecutive cycles, the filtered output SHALL take the new value and the counter SHALL clear. Total latency from raw change to FILT change = SYNC_STAGES+FILTER_LEN cycles.
REQ-019 START_DET SHALL pulse in the cycle after SDA_FILT goes 1->0 while SCL_FILT is 1 in both the previous and current cycle.
REQ-020 STOP_DET SHALL pulse in the cycle after SDA_FILT goes 0->1 under the same SCL condition.
REQ-021 If SCL_FILT and SDA_FILT change in the same cycle, the block SHALL detect neither START nor STOP.
REQ-022 Bus state machine IDLE/BUSY: IDLE->BUSY on START; BUSY->IDLE on STOP; a repeated START in BUSY SHALL pulse START_DET and stay BUSY. BUS_BUSY = (state == BUSY).
REQ-023 ARB_LOST[i] SHALL set when, in BUSY, SCL_FILT rises and device i releases SDA (OEN=1 or O=1) while SDA_FILT is 0 and some other device drives SDA low.
REQ-024 ARB_CLR[i] SHALL clear ARB_LOST[i] on the next edge; simultaneous set and clear SHALL leave the flag set.

Reset
REQ-025 On WB_RST_I the following SHALL be set asynchronously: synchronizer flops and FILT outputs 1; filter counters 0; state IDLE; START_DET, STOP_DET, BUS_BUSY, ARB_LOST, SCL_TIMEOUT 0. PAD_I outputs SHALL stay combinational.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer; after release, no START/STOP SHALL be reported until a fresh edge is filtered.

Configuration
REQ-027 With I2C_BUS_TIMEOUT_EN defined, a counter SHALL count cycles with SCL_FILT=0 in BUSY; reaching TIMEOUT_CYC SHALL set SCL_TIMEOUT, which SHALL clear on STOP_DET or reset; the counter SHALL clear whenever SCL_FILT=1.
REQ-028 Without I2C_BUS_TIMEOUT_EN, the counter SHALL be absent and SCL_TIMEOUT SHALL be tied to 0.

Structure
REQ-029 Package i2c_bus_pkg SHALL hold the bus-state enum (IDLE, BUSY), the parameter default constants and the range limits.
REQ-030 Sub-module i2c_line_filter (synchronizer + glitch filter) SHALL be instantiated once for SCL and once for SDA.

Verification
REQ-031 NUM_DEV=2, FILTER_LEN=4: dev0 pulls SDA low for 3 cycles -> SDA_PAD_I low 3 cycles, SDA_FILT stays 1, no START_DET.
REQ-032 SCL=1, SDA 1->0 held -> SDA_FILT falls 6 cycles later, START_DET pulses 1 cycle, BUS_BUSY=1; SDA 0->1 with SCL=1 -> STOP_DET pulses, BUS_BUSY=0.
REQ-033 Drive SCL and SDA to 0 in the same cycle -> neither START_DET nor STOP_DET.
REQ-034 In BUSY, dev0 releases SDA, dev1 drives 0, SCL rises -> ARB_LOST=2'b01; ARB_CLR[0] asserted on the set cycle -> flag stays 1; ARB_CLR[0] asserted later -> 0.
REQ-035 With I2C_BUS_TIMEOUT_EN and TIMEOUT_CYC=20: hold SCL low 30 cycles in BUSY -> SCL_TIMEOUT=1; STOP -> 0. Without the macro -> SCL_TIMEOUT stays 0.
REQ-036 Assert WB_RST_I mid-transfer -> all flags 0 and FILT outputs 1 immediately; BUS_BUSY=0 after release.
